// File: rtl/branch_resolve_unit_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit_pkg
// Shared definitions for the EX-stage branch resolve unit: the FSM state
// encoding, the sequential fetch increment and the JALR target alignment mask.
// -----------------------------------------------------------------------------
package branch_resolve_unit_pkg;

    // Resolve FSM: IDLE resolves EX, FLUSH is the single redirect/kill cycle.
    typedef enum logic [0:0] {
        BRU_IDLE  = 1'b0,
        BRU_FLUSH = 1'b1
    } bru_state_e;

    // Fall-through distance of a 32-bit RV32I instruction.
    localparam logic [31:0] PC_INC = 32'd4;

    // JALR targets always have bit 0 cleared.
    localparam logic [31:0] JALR_ALIGN_MASK = ~32'h1;

endpackage : branch_resolve_unit_pkg

// File: rtl/bru_target_calc.sv
// -----------------------------------------------------------------------------
// bru_target_calc
// Combinational outcome calculator for the instruction in EX.
// Inputs : instruction class flags, pc, imm, forwarded rs1, ALU branch flag,
//          IF prediction (taken + target) and the resolve qualifier.
// Outputs: actual taken, actual target, fall-through pc, mispredict flag.
// All additions wrap modulo 2^XLEN.
// -----------------------------------------------------------------------------
module bru_target_calc
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            res,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic            alu_f,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] fall_thru,
    output logic            mis
);

    // Sign-extending the 32-bit mask keeps all upper bits set for wider XLEN.
    localparam logic [XLEN-1:0] ALIGN_MASK_X = XLEN'($signed(JALR_ALIGN_MASK));
    localparam logic [XLEN-1:0] PC_INC_X     = XLEN'(PC_INC);

    logic [XLEN-1:0] pc_rel_s;
    logic [XLEN-1:0] rs1_rel_s;

    // Outcome, target and mispredict evaluation for the current EX contents.
    always_comb begin
        pc_rel_s  = ex_pc + ex_imm;
        rs1_rel_s = (ex_rs1 + ex_imm) & ALIGN_MASK_X;
        fall_thru = ex_pc + PC_INC_X;
        taken     = ex_is_jal | ex_is_jalr | (ex_is_branch & alu_f);
        if (ex_is_jalr) begin
            target = rs1_rel_s;
        end else begin
            target = pc_rel_s;
        end
        // A non-control instruction predicted taken is a mispredict too.
        mis = res & ((taken != ex_pred_taken) |
                     (taken & ex_pred_taken & (target != ex_pred_target)));
    end

endmodule : bru_target_calc

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// EX-stage branch/jump resolution for the pipelined RV32I core. Compares the
// actual outcome with the IF prediction, issues a registered one-cycle
// redirect plus IF/ID and ID/EX flush on mispredict, and emits a predictor
// update beat for every resolved control-flow instruction.
//
// Ports:
//   cpu_clk, cpu_rst         clock, synchronous active-high reset
//   ex_*                     EX instruction info (valid, stall, class, pc,
//                            imm, rs1, prediction)
//   alu_f                    ALU branch condition
//   redirect_valid/pc        one-cycle redirect to IF (pc held between events)
//   flush_if_id/flush_id_ex  one-cycle pipeline kills
//   upd_valid/pc/taken/target predictor update (fields held between beats)
//   perf_br_cnt/perf_mis_cnt saturating perf counters
//
// Optional feature macro: BRU_PERF_EN (perf counters present when defined,
// otherwise both perf ports are constant 0).
// -----------------------------------------------------------------------------
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic             ex_is_branch,
    input  logic             ex_is_jal,
    input  logic             ex_is_jalr,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic             alu_f,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             upd_valid,
    output logic [XLEN-1:0]  upd_pc,
    output logic             upd_taken,
    output logic [XLEN-1:0]  upd_target,
    output logic [CNT_W-1:0] perf_br_cnt,
    output logic [CNT_W-1:0] perf_mis_cnt
);

    bru_state_e      state_r;
    logic            res_s;
    logic            is_cf_s;
    logic            taken_s;
    logic            mis_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] fall_thru_s;

    // Resolve qualifier: FLUSH blocks the wrong-path instruction in EX.
    assign res_s   = ex_valid & ~ex_stall & (state_r == BRU_IDLE);
    assign is_cf_s = ex_is_branch | ex_is_jal | ex_is_jalr;

    bru_target_calc #(.XLEN(XLEN)) u_calc (
        .res            (res_s),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jal      (ex_is_jal),
        .ex_is_jalr     (ex_is_jalr),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_rs1         (ex_rs1),
        .alu_f          (alu_f),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .taken          (taken_s),
        .target         (target_s),
        .fall_thru      (fall_thru_s),
        .mis            (mis_s)
    );

    // Resolve FSM and registered redirect/flush/update outputs.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_r        <= BRU_IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= {XLEN{1'b0}};
            flush_if_id    <= 1'b0;
            flush_id_ex    <= 1'b0;
            upd_valid      <= 1'b0;
            upd_pc         <= {XLEN{1'b0}};
            upd_taken      <= 1'b0;
            upd_target     <= {XLEN{1'b0}};
        end else begin
            // Strobes default low; data fields hold their last values.
            redirect_valid <= 1'b0;
            flush_if_id    <= 1'b0;
            flush_id_ex    <= 1'b0;
            upd_valid      <= 1'b0;
            case (state_r)
                BRU_IDLE: begin
                    if (res_s && is_cf_s) begin
                        upd_valid  <= 1'b1;
                        upd_pc     <= ex_pc;
                        upd_taken  <= taken_s;
                        upd_target <= target_s;
                    end else begin
                        upd_valid  <= 1'b0;
                    end
                    if (mis_s) begin
                        state_r        <= BRU_FLUSH;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= taken_s ? target_s : fall_thru_s;
                        flush_if_id    <= 1'b1;
                        flush_id_ex    <= 1'b1;
                    end else begin
                        state_r        <= BRU_IDLE;
                    end
                end
                // The redirect pulse is already out; leave regardless of stall.
                BRU_FLUSH: begin
                    state_r <= BRU_IDLE;
                end
                default: begin
                    state_r <= BRU_IDLE;
                end
            endcase
        end
    end

`ifdef BRU_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] br_cnt_r;
    logic [CNT_W-1:0] mis_cnt_r;

    // Saturating counters driven by the registered strobes.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            br_cnt_r  <= {CNT_W{1'b0}};
            mis_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (upd_valid && (br_cnt_r != CNT_MAX)) begin
                br_cnt_r <= br_cnt_r + CNT_ONE;
            end else begin
                br_cnt_r <= br_cnt_r;
            end
            if (redirect_valid && (mis_cnt_r != CNT_MAX)) begin
                mis_cnt_r <= mis_cnt_r + CNT_ONE;
            end else begin
                mis_cnt_r <= mis_cnt_r;
            end
        end
    end

    assign perf_br_cnt  = br_cnt_r;
    assign perf_mis_cnt = mis_cnt_r;
`else
    assign perf_br_cnt  = {CNT_W{1'b0}};
    assign perf_mis_cnt = {CNT_W{1'b0}};
`endif

endmodule : branch_resolve_unit

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Directed table-driven bench for branch_resolve_unit plus hand sequences for
// stall release, back-to-back mispredict and reset during FLUSH.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [31:0] ex_pc, ex_imm, ex_rs1, ex_pred_target;
    logic        alu_f, ex_pred_taken;
    logic        redirect_valid, flush_if_id, flush_id_ex, upd_valid, upd_taken;
    logic [31:0] redirect_pc, upd_pc, upd_target, perf_br_cnt, perf_mis_cnt;

    int total = 0;
    int bad   = 0;
    int exp_br  = 0;
    int exp_mis = 0;

    branch_resolve_unit #(.XLEN(32), .CNT_W(32)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .ex_valid(ex_valid), .ex_stall(ex_stall),
        .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .alu_f(alu_f),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target),
        .perf_br_cnt(perf_br_cnt), .perf_mis_cnt(perf_mis_cnt)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic        br, jal, jalr;
        logic [31:0] pc, imm, rs1;
        logic        f, pt;
        logic [31:0] ptgt;
        logic        e_red;
        logic [31:0] e_rpc;
        logic        e_upd, e_tk;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic br, input logic jal, input logic jalr,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] rs1, input logic f, input logic pt,
                                input logic [31:0] ptgt, input logic e_red,
                                input logic [31:0] e_rpc, input logic e_upd,
                                input logic e_tk, input logic [31:0] e_tgt);
        vec_t v;
        v.br = br; v.jal = jal; v.jalr = jalr; v.pc = pc; v.imm = imm; v.rs1 = rs1;
        v.f = f; v.pt = pt; v.ptgt = ptgt; v.e_red = e_red; v.e_rpc = e_rpc;
        v.e_upd = e_upd; v.e_tk = e_tk; v.e_tgt = e_tgt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_stall = 1'b0; ex_is_branch = 1'b0; ex_is_jal = 1'b0;
        ex_is_jalr = 1'b0; ex_pc = 32'h0; ex_imm = 32'h0; ex_rs1 = 32'h0;
        alu_f = 1'b0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
    endtask

    task automatic drive(input vec_t v);
        ex_valid = 1'b1; ex_stall = 1'b0;
        ex_is_branch = v.br; ex_is_jal = v.jal; ex_is_jalr = v.jalr;
        ex_pc = v.pc; ex_imm = v.imm; ex_rs1 = v.rs1; alu_f = v.f;
        ex_pred_taken = v.pt; ex_pred_target = v.ptgt;
    endtask

    task automatic chk_strobes_low(input string nm);
        chk({nm, ".redir"}, {31'h0, redirect_valid}, 32'h0);
        chk({nm, ".fifd"},  {31'h0, flush_if_id},    32'h0);
        chk({nm, ".fidex"}, {31'h0, flush_id_ex},    32'h0);
        chk({nm, ".upd"},   {31'h0, upd_valid},      32'h0);
    endtask

    task automatic chk_perf(input string nm);
`ifdef BRU_PERF_EN
        chk({nm, ".perf_br"},  perf_br_cnt,  exp_br);
        chk({nm, ".perf_mis"}, perf_mis_cnt, exp_mis);
`else
        chk({nm, ".perf_br"},  perf_br_cnt,  32'h0);
        chk({nm, ".perf_mis"}, perf_mis_cnt, 32'h0);
`endif
    endtask

    task automatic chk_all_zero(input string nm);
        chk_strobes_low(nm);
        chk({nm, ".rpc"},  redirect_pc,         32'h0);
        chk({nm, ".upc"},  upd_pc,              32'h0);
        chk({nm, ".utk"},  {31'h0, upd_taken},  32'h0);
        chk({nm, ".utgt"}, upd_target,          32'h0);
        chk({nm, ".pbr"},  perf_br_cnt,         32'h0);
        chk({nm, ".pmis"}, perf_mis_cnt,        32'h0);
    endtask

    initial begin
        // br jal jalr pc imm rs1 f pt ptgt | red rpc upd tk tgt
        vecs[0]  = mk(1,0,0, 32'h100, 32'h20, 32'h0, 1,0, 32'h0,   1, 32'h120, 1,1, 32'h120);
        vecs[1]  = mk(1,0,0, 32'h200, 32'h40, 32'h0, 0,0, 32'h0,   0, 32'h0,   1,0, 32'h240);
        vecs[2]  = mk(0,0,1, 32'h300, 32'h4,  32'h1003, 0,1, 32'h1000, 1, 32'h1006, 1,1, 32'h1006);
        vecs[3]  = mk(1,0,0, 32'h400, 32'h10, 32'h0, 0,1, 32'h410, 1, 32'h404, 1,0, 32'h410);
        vecs[4]  = mk(0,1,0, 32'h500, 32'hFFFFFF00, 32'h0, 0,1, 32'h400, 0, 32'h0, 1,1, 32'h400);
        vecs[5]  = mk(0,1,0, 32'hFFFFFFF0, 32'h20, 32'h0, 0,0, 32'h0, 1, 32'h10, 1,1, 32'h10);
        vecs[6]  = mk(0,0,0, 32'h600, 32'h0,  32'h0, 0,1, 32'h700, 1, 32'h604, 0,0, 32'h0);
        vecs[7]  = mk(0,0,0, 32'hFFFFFFFC, 32'h0, 32'h0, 0,1, 32'h8, 1, 32'h0, 0,0, 32'h0);
        vecs[8]  = mk(1,0,0, 32'h800, 32'h80, 32'h0, 1,1, 32'h880, 0, 32'h0, 1,1, 32'h880);
        vecs[9]  = mk(0,0,1, 32'h900, 32'h10, 32'h2000, 0,1, 32'h2010, 0, 32'h0, 1,1, 32'h2010);
        vecs[10] = mk(0,0,0, 32'hA00, 32'h0,  32'h0, 0,0, 32'h0,   0, 32'h0,   0,0, 32'h0);

        idle_inputs();
        cpu_rst = 1'b1;
        repeat (3) @(negedge cpu_clk);
        chk_all_zero("reset");
        cpu_rst = 1'b0;
        @(negedge cpu_clk);

        // Table-driven single-instruction vectors.
        for (int i = 0; i < 11; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            drive(vecs[i]);
            @(negedge cpu_clk);
            idle_inputs();
            chk({nm, ".redir"}, {31'h0, redirect_valid}, {31'h0, vecs[i].e_red});
            chk({nm, ".fifd"},  {31'h0, flush_if_id},    {31'h0, vecs[i].e_red});
            chk({nm, ".fidex"}, {31'h0, flush_id_ex},    {31'h0, vecs[i].e_red});
            chk({nm, ".upd"},   {31'h0, upd_valid},      {31'h0, vecs[i].e_upd});
            if (vecs[i].e_red) begin
                chk({nm, ".rpc"}, redirect_pc, vecs[i].e_rpc);
                exp_mis++;
            end
            if (vecs[i].e_upd) begin
                chk({nm, ".upc"},  upd_pc,             vecs[i].pc);
                chk({nm, ".utk"},  {31'h0, upd_taken}, {31'h0, vecs[i].e_tk});
                chk({nm, ".utgt"}, upd_target,         vecs[i].e_tgt);
                exp_br++;
            end
            @(negedge cpu_clk);
            chk_strobes_low({nm, ".after"});
            chk_perf(nm);
        end

        // Branch held by a 3-cycle stall, resolves once after release.
        drive(mk(1,0,0, 32'hB00, 32'h30, 32'h0, 1,0, 32'h0, 0,0,0,0,0));
        ex_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge cpu_clk);
            chk_strobes_low($sformatf("stall%0d", c));
        end
        ex_stall = 1'b0;
        @(negedge cpu_clk);
        idle_inputs();
        chk("stall.redir", {31'h0, redirect_valid}, 32'h1);
        chk("stall.rpc",   redirect_pc,             32'hB30);
        chk("stall.upd",   {31'h0, upd_valid},      32'h1);
        exp_mis++; exp_br++;
        @(negedge cpu_clk);
        chk_strobes_low("stall.after");
        @(negedge cpu_clk);
        chk_strobes_low("stall.after2");
        chk_perf("stall");

        // Back-to-back: second mispredicting branch sits in EX during FLUSH,
        // held by a stall as well; only the first redirects.
        drive(mk(1,0,0, 32'hC00, 32'h40, 32'h0, 1,0, 32'h0, 0,0,0,0,0));
        @(negedge cpu_clk);
        drive(mk(1,0,0, 32'hD00, 32'h80, 32'h0, 1,0, 32'h0, 0,0,0,0,0));
        ex_stall = 1'b1;
        chk("b2b.redir1", {31'h0, redirect_valid}, 32'h1);
        chk("b2b.rpc1",   redirect_pc,             32'hC40);
        exp_mis++; exp_br++;
        @(negedge cpu_clk);
        ex_stall = 1'b0;
        ex_valid = 1'b0;
        chk_strobes_low("b2b.second");
        chk("b2b.rpc_hold", redirect_pc, 32'hC40);
        chk("b2b.upc_hold", upd_pc,      32'hC00);
        @(negedge cpu_clk);
        chk_strobes_low("b2b.after");
        chk_perf("b2b");

        // Reset asserted while in FLUSH wipes the pending pulse and state.
        drive(mk(0,1,0, 32'hE00, 32'h100, 32'h0, 0,0, 32'h0, 0,0,0,0,0));
        @(negedge cpu_clk);
        idle_inputs();
        chk("rstfl.redir", {31'h0, redirect_valid}, 32'h1);
        cpu_rst = 1'b1;
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        chk_all_zero("rstfl");
        exp_br = 0; exp_mis = 0;
        // Unit must be back in IDLE: a correctly predicted branch resolves.
        drive(mk(1,0,0, 32'hF00, 32'h8, 32'h0, 1,1, 32'hF08, 0,0,0,0,0));
        @(negedge cpu_clk);
        idle_inputs();
        chk("post.upd",   {31'h0, upd_valid},      32'h1);
        chk("post.redir", {31'h0, redirect_valid}, 32'h0);
        chk("post.upc",   upd_pc,                  32'hF00);
        chk("post.utgt",  upd_target,              32'hF08);
        exp_br++;
        @(negedge cpu_clk);
        chk_perf("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_branch_resolve_unit
